// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and elaboration-time helpers for the CNN datapath.
// Contents:
//   DATA_WIDTH_DEF - default pixel width
//   clog2          - ceiling log2 (0 for values <= 1)
//   cnt_w          - counter width that never collapses to zero bits
//   idx_w          - in-window index width, clog2(POOL*POOL)
//   win_cols       - number of pooling windows across a row, IMG_W/POOL
package cnn_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

  function automatic int idx_w(input int pool);
    return clog2(pool * pool);
  endfunction

  function automatic int win_cols(input int img_w, input int pool);
    return img_w / pool;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// max_cmp: combinational two-operand maximum with index tracking.
// 'a' is the incumbent and 'b' the challenger; b wins only when strictly
// greater, so ties keep the earlier value and its index.
// Ports:
//   a, b          - operands (DATA_WIDTH)
//   a_idx, b_idx  - operand indices (IDX_W)
//   max, max_idx  - winning value and its index
// Parameter SIGNED selects two's-complement (1) or unsigned (0) compare.
module max_cmp #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 2,
  parameter bit SIGNED     = 1'b1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [IDX_W-1:0]      a_idx,
  input  logic [IDX_W-1:0]      b_idx,
  output logic [DATA_WIDTH-1:0] max,
  output logic [IDX_W-1:0]      max_idx
);

  logic w_b_gt;

  // Strict-greater test in the configured number representation
  always_comb begin
    w_b_gt = 1'b0;
    if (SIGNED) begin
      w_b_gt = ($signed(b) > $signed(a));
    end else begin
      w_b_gt = (b > a);
    end
  end

  // Select winner and its index
  always_comb begin
    max     = a;
    max_idx = a_idx;
    if (w_b_gt) begin
      max     = b;
      max_idx = b_idx;
    end else begin
      max     = a;
      max_idx = a_idx;
    end
  end

endmodule

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming POOL x POOL max-pooling over raster-order pixels.
// One pixel per beat in, one maximum per window out, valid/ready both sides.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_data/in_valid/in_ready    - input pixel stream
//   out_data/out_valid/out_ready - window-maximum stream
//   out_last              - marks the final output of a frame
//   out_idx               - (MAX_POOL_ARGMAX_EN only) raster position of the
//                           winner inside its window
// Optional feature macro: MAX_POOL_ARGMAX_EN.
module max_pool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int POOL       = 2,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef MAX_POOL_ARGMAX_EN
  ,
  output logic [idx_w(POOL)-1:0] out_idx
`endif
);

  localparam int WIN_COLS = win_cols(IMG_W, POOL);
  localparam int IDX_W    = idx_w(POOL);
  localparam int PW       = cnt_w(POOL);
  localparam int WC_W     = cnt_w(WIN_COLS);
  localparam int ROW_W    = cnt_w(IMG_H);

  localparam logic [PW-1:0]    P_LAST   = PW'(POOL - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WIN_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || POOL < 2) begin : g_param_check
    $error("max_pool_stream: IMG_W and IMG_H must be multiples of POOL, and POOL >= 2");
  end

  // Column is tracked as (window column, offset inside window) and row as
  // (absolute row, offset inside window) so no divide/modulo is needed.
  logic [PW-1:0]    r_col_in;
  logic [WC_W-1:0]  r_wc;
  logic [PW-1:0]    r_row_in;
  logic [ROW_W-1:0] r_row;

  logic [DATA_WIDTH-1:0] r_partial [WIN_COLS];
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_accept;
  logic                  w_first;
  logic                  w_last_elem;
  logic                  w_frame_end;
  logic [DATA_WIDTH-1:0] w_max;
  logic [IDX_W-1:0]      w_max_idx;
  logic [IDX_W-1:0]      w_a_idx;
  logic [IDX_W-1:0]      w_b_idx;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_first     = (r_row_in == '0) && (r_col_in == '0);
  assign w_last_elem = (r_row_in == P_LAST) && (r_col_in == P_LAST);
  assign w_frame_end = (r_row == ROW_LAST) && (r_wc == WC_LAST);

`ifdef MAX_POOL_ARGMAX_EN
  logic [IDX_W-1:0] r_pidx [WIN_COLS];
  logic [IDX_W-1:0] r_out_idx;

  assign w_a_idx = r_pidx[r_wc];
  assign w_b_idx = IDX_W'(int'(r_row_in) * POOL + int'(r_col_in));
  assign out_idx = r_out_idx;

  // Index buffer runs alongside the partial maxima
  always_ff @(posedge clk) begin
    if (w_accept && !w_last_elem) begin
      r_pidx[r_wc] <= w_first ? w_b_idx : w_max_idx;
    end
  end

  // Registered winner index, same timing as out_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_idx <= '0;
    end else if (w_accept && w_last_elem) begin
      r_out_idx <= w_max_idx;
    end
  end
`else
  logic [IDX_W-1:0] w_unused_idx;

  assign w_a_idx      = '0;
  assign w_b_idx      = '0;
  assign w_unused_idx = w_max_idx;
`endif

  max_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W),
    .SIGNED     (SIGNED)
  ) u_max_cmp (
    .a       (r_partial[r_wc]),
    .b       (in_data),
    .a_idx   (w_a_idx),
    .b_idx   (w_b_idx),
    .max     (w_max),
    .max_idx (w_max_idx)
  );

  // Raster position counters; advance only on accepted pixels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_in <= '0;
      r_wc     <= '0;
      r_row_in <= '0;
      r_row    <= '0;
    end else if (w_accept) begin
      if (r_col_in == P_LAST) begin
        r_col_in <= '0;
        if (r_wc == WC_LAST) begin
          r_wc     <= '0;
          r_row_in <= (r_row_in == P_LAST) ? '0 : r_row_in + 1'b1;
          r_row    <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_wc <= r_wc + 1'b1;
        end
      end else begin
        r_col_in <= r_col_in + 1'b1;
      end
    end
  end

  // Running maxima; a window's first pixel overwrites any stale content.
  // The closing pixel goes straight to the output register instead.
  always_ff @(posedge clk) begin
    if (w_accept && !w_last_elem) begin
      r_partial[r_wc] <= w_first ? in_data : w_max;
    end
  end

  // Output register: load on window close, otherwise clear on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_last_elem) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_max;
      r_out_last  <= w_frame_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_max_pool_stream.sv
module tb_max_pool_stream;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int IH = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   idx;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         out_ready;

  logic         ir_s, ir_u, ov_s, ov_u, ol_s, ol_u;
  logic [W-1:0] od_s, od_u;
  logic [1:0]   oi_s, oi_u;

  exp_t         q_s[$];
  exp_t         q_u[$];
  logic [W-1:0] log_s[$];
  logic [W-1:0] log_u[$];

  int checks   = 0;
  int failures = 0;
  int gap_pct  = 0;
  int rdy_pct  = 100;
  bit exp_valid_next = 1'b0;

  // model state
  int           m_r = 0;
  int           m_c = 0;
  logic [W-1:0] img [IH][IW];

  always #5 clk = ~clk;

  max_pool_stream #(.DATA_WIDTH(W), .IMG_W(IW), .IMG_H(IH), .POOL(2), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_s),
    .out_data(od_s), .out_valid(ov_s), .out_ready(out_ready), .out_last(ol_s)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_idx(oi_s)
`endif
  );

  max_pool_stream #(.DATA_WIDTH(W), .IMG_W(IW), .IMG_H(IH), .POOL(2), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_u),
    .out_data(od_u), .out_valid(ov_u), .out_ready(out_ready), .out_last(ol_u)
`ifdef MAX_POOL_ARGMAX_EN
    , .out_idx(oi_u)
`endif
  );

`ifndef MAX_POOL_ARGMAX_EN
  assign oi_s = 2'd0;
  assign oi_u = 2'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: window max by scanning the stored frame in raster order
  task automatic model_accept(input logic [W-1:0] d);
    exp_t es, eu;
    int r0, c0;
    logic [W-1:0] v;
    img[m_r][m_c] = d;
    if ((m_r % 2 == 1) && (m_c % 2 == 1)) begin
      r0 = m_r - 1;
      c0 = m_c - 1;
      es.d = img[r0][c0]; es.idx = 2'd0;
      eu.d = img[r0][c0]; eu.idx = 2'd0;
      for (int k = 1; k < 4; k++) begin
        v = img[r0 + k / 2][c0 + k % 2];
        if ($signed(v) > $signed(es.d)) begin es.d = v; es.idx = 2'(k); end
        if (v > eu.d) begin eu.d = v; eu.idx = 2'(k); end
      end
      es.last = (m_r == IH - 1) && (m_c == IW - 1);
      eu.last = es.last;
      q_s.push_back(es);
      q_u.push_back(eu);
      exp_valid_next = 1'b1;
    end
    m_c++;
    if (m_c == IW) begin
      m_c = 0;
      m_r = (m_r == IH - 1) ? 0 : m_r + 1;
    end
  endtask

  // One clock of stimulus; reports whether the pixel is taken at the next edge
  task automatic cycle(input bit v, input logic [W-1:0] d, output bit acc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    if (exp_valid_next) begin
      check("latency_out_valid", {31'd0, ov_s}, 32'd1);
      exp_valid_next = 1'b0;
    end
    if (ov_s && !out_ready) check("backpressure_in_ready", {31'd0, ir_s}, 32'd0);
    acc = v && ir_s;
    if (acc) model_accept(d);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit acc;
    int n;
    while ($urandom_range(99) < gap_pct) cycle(1'b0, '0, acc);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 2000) begin
      cycle(1'b1, d, acc);
      n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic send_frame(input int kind);
    logic [W-1:0] d;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (kind == 1) d = W'(r * IW + c);
        else if (kind == 2) begin
          if (r == 0 && c == 0) d = 16'h1000;
          else if (r < 2 && c < 2 && !(r == 1 && c == 1)) d = 16'hCCCC;
          else if (r == 1 && c == 1) d = 16'h3000;
          else d = 16'h0001;
        end else d = W'($urandom);
        send(d);
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    rdy_pct = 100;
    n = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && n < 200) begin
      cycle(1'b0, '0, acc);
      n++;
    end
    cycle(1'b0, '0, acc);
    check("drain_q_s_empty", q_s.size(), 32'd0);
    check("drain_q_u_empty", q_u.size(), 32'd0);
  endtask

  task automatic mon_one(input logic v, input logic [W-1:0] d, input logic l,
                         input logic [1:0] idx, ref exp_t q[$], ref logic [W-1:0] lg[$],
                         input string tag);
    exp_t e;
    if (v && out_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s_unexpected_output actual=%0h required=none", tag, d);
      end else begin
        e = q.pop_front();
        check({tag, "_out_data"}, d, e.d);
        check({tag, "_out_last"}, {31'd0, l}, {31'd0, e.last});
`ifdef MAX_POOL_ARGMAX_EN
        check({tag, "_out_idx"}, {30'd0, idx}, {30'd0, e.idx});
`endif
        lg.push_back(d);
      end
    end
  endtask

  // Monitor: sample well after the input-drive point, before the next edge
  initial begin
    logic         stall_prev;
    logic [W-1:0] d_prev;
    stall_prev = 1'b0;
    d_prev     = '0;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid_held", {31'd0, ov_s}, 32'd1);
          check("stall_data_stable", od_s, d_prev);
        end
        stall_prev = ov_s && !out_ready;
        d_prev     = od_s;
        mon_one(ov_s, od_s, ol_s, oi_s, q_s, log_s, "s");
        mon_one(ov_u, od_u, ol_u, oi_u, q_u, log_u, "u");
      end
    end
  end

  initial begin
    bit acc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", {31'd0, ov_s}, 32'd0);
    check("reset_out_data", od_s, 32'd0);
    check("reset_out_last", {31'd0, ol_u}, 32'd0);
    check("reset_out_idx", {30'd0, oi_s}, 32'd0);
    reset = 1'b0;

    // Tie / signedness window
    gap_pct = 0; rdy_pct = 100;
    send_frame(2);
    drain();
    check("tp1_signed_max", log_s[0], 32'h3000);
    check("tp1_unsigned_max", log_u[0], 32'hCCCC);

    // Ramp, two frames back to back
    log_s.delete(); log_u.delete();
    send_frame(1);
    send_frame(1);
    drain();
    check("ramp_count", log_s.size(), 32'd8);
    for (int i = 0; i < 8 && i < log_s.size(); i++) begin
      case (i % 4)
        0: check("ramp_out", log_s[i], 32'd5);
        1: check("ramp_out", log_s[i], 32'd7);
        2: check("ramp_out", log_s[i], 32'd13);
        default: check("ramp_out", log_s[i], 32'd15);
      endcase
    end

    // Backpressure: stall on a pending result, then release
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) send(W'(100 + i));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'd106, acc);
      check("bp_no_accept", {31'd0, acc}, 32'd0);
    end
    rdy_pct = 100;
    for (int i = 6; i < 16; i++) send(W'(100 + i));
    drain();

    // Random gaps and backpressure over three frames
    gap_pct = 30; rdy_pct = 60;
    repeat (3) send_frame(0);
    gap_pct = 0;
    drain();

    // Reset mid-frame with a pending output
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) send(W'($urandom));
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midreset_out_valid", {31'd0, ov_s}, 32'd0);
    check("midreset_out_data", od_u, 32'd0);
    q_s.delete(); q_u.delete();
    m_r = 0; m_c = 0;
    exp_valid_next = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    rdy_pct = 100;
    log_s.delete();
    send_frame(0);
    drain();
    check("post_reset_output_count", log_s.size(), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming max-pooling unit for the CNN datapath.
- Successor to the fixed 4-input combinational max: pixels arrive one per beat in raster order, and the block emits one maximum per POOL x POOL window.
- Parametrised in data width, image size, pool size and signed/unsigned compare.
- Sits between a convolution/activation stage and the next layer. Valid/ready on both sides.

Parameters:
- DATA_WIDTH, 16, pixel width in bits.
- IMG_W, 28, input image width in pixels; must be a multiple of POOL.
- IMG_H, 28, input image height in pixels; must be a multiple of POOL.
- POOL, 2, window edge and stride; must be ≥2.
- SIGNED, 1: 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_WIDTH  input pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a pixel this cycle.
- out_data  out  DATA_WIDTH  window maximum.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  qualifies the final output of a frame.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Reset forces out_valid=0, out_data=0, out_last=0, and row/column counters to 0.
- Accept condition: a pixel is accepted when in_valid && in_ready.
- Backpressure rule: in_ready = !out_valid || out_ready, combinational.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on each accepted pixel. col wraps to 0 and increments row. row wraps to 0 after the last pixel of a frame. Frames are back-to-back with no gap required.
- Partial buffer: IMG_W/POOL entries of DATA_WIDTH, indexed by wc = col/POOL. No reset is needed.
- First element of a window (row%POOL==0 && col%POOL==0): partial[wc] <= in_data.
- Other window elements: partial[wc] <= max(partial[wc], in_data).
- Last element of a window (row%POOL==POOL-1 && col%POOL==POOL-1):
  - the max is computed combinationally;
  - out_data is registered with it and out_valid is set on the next edge (latency 1 cycle from acceptance);
  - the partial write is not needed.
- out_last: set with the output produced by pixel (IMG_H-1, IMG_W-1).
- Output handshake: out_valid is held with out_data stable until out_ready. It clears on handshake unless a new result loads in the same cycle; accept and emit in the same cycle is allowed (full throughput, one pixel per cycle).
- Compare rule: replace only when strictly greater, so ties keep the earlier value.
  - SIGNED=1: operands compared as two's complement.
  - SIGNED=0: operands compared as unsigned (0xCCCC > 0x3000).
- Stall: in_valid low stalls the counters, with no state change.
- Reset mid-frame: the partial frame is discarded, the next accepted pixel is (0,0), and any pending output is dropped.
- Parameter check: non-divisible IMG_W/IMG_H or POOL<2 causes an elaboration-time $error.

Optional Feature:
- MAX_POOL_ARGMAX_EN defined:
  - adds output port out_idx, width clog2(POOL*POOL);
  - out_idx is the raster position of the winner inside its window (0..POOL*POOL-1); on ties the earliest index is kept;
  - an index buffer of IMG_W/POOL entries runs alongside the partials;
  - out_idx resets to 0 and follows the same timing as out_data.
- Undefined: no out_idx port and no index storage; behaviour is otherwise identical.

Decomposition:
- Package cnn_pkg:
  - default DATA_WIDTH;
  - clog2 helper function;
  - index-width localparam derivation (IDX_W = clog2(POOL*POOL), WIN_COLS = IMG_W/POOL).
- Sub-module max_cmp (combinational):
  - ports a, b, a_idx, b_idx, and SIGNED as a parameter;
  - outputs max and max_idx with the strict-greater rule;
  - it is the single compare used for the running max.

Test Plan:
- POOL=2, IMG_W=IMG_H=2, SIGNED=0, stream 0x1000,0xCCCC,0xCCCC,0x3000 -> one output 0xCCCC, out_last=1, one cycle after the 4th accept. With ARGMAX: out_idx=1 (tie keeps earlier).
- Same stream with SIGNED=1 -> 0x3000. With ARGMAX: out_idx=3.
- IMG_W=IMG_H=4, POOL=2, pixels 0..15 in raster order, out_ready=1 -> outputs 5,7,13,15. out_last only on 15. Two frames streamed back-to-back give an identical repeat.
- Backpressure: out_ready=0 while a result is pending -> in_ready=0, out_data held stable, no pixel lost. Release -> outputs resume in order.
- Random in_valid gaps and random out_ready over 3 frames, checked against a software model -> every window max matches.
- Assert reset after 6 pixels of a 4x4 frame, then send a full frame -> only the 4 new-frame outputs appear. All outputs read 0/invalid during reset.
